// File: rtl/mdu_unit_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and divider sizing.
// No logic; latency and backpressure are properties of the modules that import it.
package mdu_unit_pkg;

    localparam int DIV_ITERATIONS = 32;
    localparam int CNT_W          = 5;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MTHI     = 4'd5,
        MTLO     = 4'd6,
        MFHI     = 4'd7,
        MFLO     = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per step, done pulses with the last step.
// 32 steps after load; no backpressure, the owner only asserts step while a divide is running.
module mdu_divider
    import mdu_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [32:0]      shifted;
    logic             fits;

    // A zero divisor always "fits": quotient fills with ones and the dividend ends up in the remainder.
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, dvs_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
            quo_q <= {quo_q[30:0], fits};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = step && (cnt_q == CNT_W'(DIV_ITERATIONS - 1));

endmodule

// File: rtl/mdu_unit.sv
// EXECUTE-stage multiply/divide unit owning HI/LO; MULT* lands MULT_LATENCY cycles after start, DIV* 33.
// busy stalls issue; starts while busy are dropped, flush aborts in-flight work without touching HI/LO.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_LATENCY = 5
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] readData
);

    mdu_op_e          op_e;
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic             mul_signed_q, mul_signed_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic [63:0]      prod_s, prod_u;
    logic             is_div, long_op;
    logic [31:0]      abs_a, abs_b;
    logic             div_load, div_step, div_done;
    logic [31:0]      div_quo, div_rem;

    assign op_e    = mdu_op_e'(op);
    assign is_div  = (op_e == DIV);
    assign long_op = (op_e == MULT) || (op_e == MULTU) || (op_e == DIV) || (op_e == DIVU);

    // Magnitudes only for signed DIV; DIVU passes operands straight through.
    assign abs_a = (is_div && operand1[31]) ? (~operand1 + 32'd1) : operand1;
    assign abs_b = (is_div && operand2[31]) ? (~operand2 + 32'd1) : operand2;

    assign prod_s = $signed({{32{mul_a_q[31]}}, mul_a_q}) * $signed({{32{mul_b_q[31]}}, mul_b_q});
    assign prod_u = {32'd0, mul_a_q} * {32'd0, mul_b_q};

    mdu_divider u_divider (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        quo_neg_d    = quo_neg_q;
        rem_neg_d    = rem_neg_q;
        div_load     = 1'b0;
        div_step     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_e)
                            MULT, MULTU: begin
                                mul_a_d      = operand1;
                                mul_b_d      = operand2;
                                mul_signed_d = (op_e == MULT);
                                cnt_d        = CNT_W'(MULT_LATENCY - 1);
                                state_d      = MUL_WAIT;
                            end
                            DIV, DIVU: begin
                                div_load  = 1'b1;
                                quo_neg_d = is_div && (operand1[31] ^ operand2[31]);
                                rem_neg_d = is_div && operand1[31];
                                cnt_d     = CNT_W'(DIV_ITERATIONS - 1);
                                state_d   = DIV_RUN;
                            end
                            MTHI:    hi_d = operand1;
                            MTLO:    lo_d = operand1;
                            default: ;
                        endcase
                    end
                end
                MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = mul_signed_q ? prod_s : prod_u;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV_RUN: begin
                    div_step = 1'b1;
                    if (div_done) state_d = DIV_FIX;
                    else          cnt_d   = cnt_q - 1'b1;
                end
                DIV_FIX: begin
                    lo_d    = quo_neg_q ? (~div_quo + 32'd1) : div_quo;
                    hi_d    = rem_neg_q ? (~div_rem + 32'd1) : div_rem;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            quo_neg_q    <= quo_neg_d;
            rem_neg_q    <= rem_neg_d;
        end
    end

    assign busy = (state_q != IDLE) || (start && long_op);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        readData = '0;
        if (op_e == MFHI)      readData = hi_q;
        else if (op_e == MFLO) readData = lo_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: issued ops push expected HI/LO and completion cycle, a monitor
// pops on every busy fall; directed edge cases followed by randomized ops against an arithmetic model.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 33;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] readData;

    mdu_unit #(.MULT_LATENCY(MUL_LAT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .readData (readData)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic        prev_busy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Architectural result as {hi, lo}, straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib;
        logic [31:0]     q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        q  = 32'd0;
        r  = 32'd0;
        case (o)
            MULT:  return sa * sb;
            MULTU: return ua * ub;
            DIVU: begin
                if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
                else begin q = a / b; r = a % b; end
            end
            DIV: begin
                if (b == 32'd0) begin q = a[31] ? 32'd1 : 32'hFFFF_FFFF; r = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = 32'd0; end
                else begin q = ia / ib; r = ia % ib; end
            end
            default: ;
        endcase
        return {r, q};
    endfunction

    always @(negedge clock) begin
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_completion: busy fell with nothing outstanding at cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.due));
                check("result_hi", hi, mon_e.hi);
                check("result_lo", lo, mon_e.lo);
            end
        end
        prev_busy = busy;
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int          lat;
        logic        long_op;
        long_op = (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
        lat     = (o == MULT || o == MULTU) ? MUL_LAT : DIV_LAT;
        @(posedge clock); #1;
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        if (long_op) begin
            r = model(o, a, b);
            exp_q.push_back('{r[63:32], r[31:0], cyc + 1 + lat});
            m_hi = r[63:32];
            m_lo = r[31:0];
        end else if (o == MTHI) m_hi = a;
        else if (o == MTLO)     m_lo = a;
        @(negedge clock);
        check("busy_at_issue", {31'd0, busy}, {31'd0, long_op});
        @(posedge clock); #1;
        start = 1'b0; op = MDU_NONE;
        if (long_op) repeat (lat) @(posedge clock);
        else begin
            @(negedge clock);
            check("move_hi", hi, m_hi);
            check("move_lo", lo, m_lo);
        end
    endtask

    task automatic read_check();
        @(posedge clock); #1;
        start = 1'b1; op = MFHI;
        @(negedge clock);
        check("readData_mfhi", readData, m_hi);
        check("busy_mfhi", {31'd0, busy}, 32'd0);
        op = MFLO; #1;
        check("readData_mflo", readData, m_lo);
        op = MDU_NONE; #1;
        check("readData_none", readData, 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = MFHI; operand1 = '0; operand2 = '0;
        repeat (2) @(posedge clock); #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_readData", readData, 32'd0);
        reset_n = 1'b1; op = MDU_NONE;

        issue(MTHI, 32'h1234_5678, 32'd0);
        issue(MTLO, 32'hDEAD_BEEF, 32'd0);
        read_check();

        issue(MULT,  32'hFFFF_FFFD, 32'd7);
        issue(MULTU, 32'hFFFF_FFFD, 32'd7);
        issue(DIV,   32'hFFFF_FFF9, 32'd2);
        issue(DIVU,  32'd100,       32'd7);
        issue(DIVU,  32'd5,         32'd0);
        issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(DIV,   32'hFFFF_FFF9, 32'd0);
        read_check();

        // Flush ten cycles into a divide; HI/LO must keep the previous result.
        @(posedge clock); #1;
        start = 1'b1; op = DIV; operand1 = 32'd1000; operand2 = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; op = MDU_NONE;
        repeat (9) @(posedge clock); #1;
        flush = 1'b1;
        exp_q.push_back('{m_hi, m_lo, cyc + 1});
        @(posedge clock); #1;
        flush = 1'b0;
        issue(MULT, 32'd12345, 32'hFFFF_FF00);

        // Flush landing on the multiply completion edge discards the product.
        @(posedge clock); #1;
        start = 1'b1; op = MULTU; operand1 = 32'd99; operand2 = 32'd77;
        @(posedge clock); #1;
        start = 1'b0; op = MDU_NONE;
        repeat (MUL_LAT - 1) @(posedge clock); #1;
        flush = 1'b1;
        exp_q.push_back('{m_hi, m_lo, cyc + 1});
        @(posedge clock); #1;
        flush = 1'b0;

        // A DIVU offered while a MULT is in flight must be ignored.
        @(posedge clock); #1;
        start = 1'b1; op = MULT; operand1 = 32'h0001_0003; operand2 = 32'hFFFF_0002;
        r = model(MULT, operand1, operand2);
        exp_q.push_back('{r[63:32], r[31:0], cyc + 1 + MUL_LAT});
        m_hi = r[63:32]; m_lo = r[31:0];
        @(posedge clock); #1;
        start = 1'b0; op = MDU_NONE;
        @(posedge clock); #1;
        start = 1'b1; op = DIVU; operand1 = 32'd100; operand2 = 32'd7;
        @(negedge clock);
        check("busy_ignored_start", {31'd0, busy}, 32'd1);
        @(posedge clock); #1;
        start = 1'b0; op = MDU_NONE;
        repeat (MUL_LAT + 4) @(posedge clock);
        read_check();

        // Asynchronous reset in the middle of a divide.
        @(posedge clock); #1;
        start = 1'b1; op = DIV; operand1 = 32'hFFFF_FF9C; operand2 = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; op = MDU_NONE;
        repeat (2) @(posedge clock); #1;
        exp_q.push_back('{32'd0, 32'd0, cyc});
        m_hi = 32'd0; m_lo = 32'd0;
        reset_n = 1'b0; #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            case ($urandom_range(0, 5))
                0:       o = MULT;
                1:       o = MULTU;
                2:       o = DIV;
                3:       o = DIVU;
                4:       o = MTHI;
                default: o = MTLO;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) b = $urandom_range(1, 9);
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(o, a, b);
            if ($urandom_range(0, 3) == 0) read_check();
        end

        repeat (5) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL outstanding_results: %0d completions never observed, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multi-cycle multiply/divide unit in the EXECUTE stage. It executes the MDU operations that the instruction decoder selects and owns the architectural HI/LO registers. It exposes a busy signal so the hazard logic stalls later MDU instructions. Reads of HI/LO (MFHI/MFLO) are served combinationally from the committed HI/LO.

Parameters:
MULT_LATENCY, 5, cycles from accepted MULT/MULTU to HI/LO update (legal range 1..8)
DIV_ITERATIONS, 32, quotient bits per divide; fixed for 32-bit datapath

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request valid in this cycle (EXECUTE stage, not stalled)
op  input  4  MduOp: MDU_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
operand1  input  32  rs value (dividend / multiplicand / MTHI-MTLO source)
operand2  input  32  rt value (divisor / multiplier)
flush  input  1  abort any in-flight operation (exception/squash)
busy  output  1  operation in flight, or start with MULT*/DIV* this cycle
hi  output  32  committed HI register
lo  output  32  committed LO register
readData  output  32  hi when op==MFHI, lo when op==MFLO, else 0

Behaviour:
- Reset (reset_n low, async): state IDLE, hi=0, lo=0, counter=0, busy=0, internal partials cleared.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- IDLE + start + MULT/MULTU: latch operands and signedness; go MUL_WAIT; counter=MULT_LATENCY-1. busy is high combinationally in the start cycle.
- MUL_WAIT: decrement counter each cycle. When counter==0: {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU); return to IDLE. The update is visible on hi/lo MULT_LATENCY cycles after the start edge; busy drops in the same cycle.
- IDLE + start + DIV/DIVU: latch the absolute values (DIV) and the result signs; go DIV_RUN; counter=DIV_ITERATIONS-1.
- DIV_RUN: one radix-2 restoring step per cycle. At counter==0, go DIV_FIX.
- DIV_FIX: apply signs. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign. Write lo=quotient, hi=remainder; go IDLE. Total latency is 33 cycles from the start edge.
- Divide by zero, no trap: lo=32'hFFFF_FFFF, hi=operand1 for DIVU. DIV uses the same raw restoring result, then sign fix.
- DIV with 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
- MTHI/MTLO with start in IDLE: write hi/lo from operand1 at the next edge. Single cycle; busy not raised.
- MFHI/MFLO: no state change. readData is combinational from committed hi/lo. Issue is gated upstream by busy.
- start while busy (state != IDLE): ignored. Upstream must stall; the bench checks that no state change occurs.
- flush: highest priority over start and completion. Next edge goes to IDLE, hi/lo are left unchanged, and the counter is cleared. If flush coincides with the completion cycle, the result is discarded.
- Reset asserted mid-operation: immediate IDLE, hi=lo=0.
- op=MDU_NONE or start=0: idle hold.

Decomposition:
- Shared package gets the MduOp enum (4-bit), the MduState enum and the DIV_ITERATIONS constant. MduOp is also driven by the decoder's new mduOp control field.
- One sub-module, mdu_divider: the iterative unsigned restoring divider with a load/step interface, a 32-bit quotient and remainder, and a done pulse.
- Sign handling, the multiply pipeline (behavioural * with a delay counter) and HI/LO stay in mdu_unit.

Test Plan:
- Reset then MTHI 0x1234_5678, MTLO 0xDEAD_BEEF -> next cycle hi=0x12345678, lo=0xDEADBEEF; MFHI gives readData=0x12345678; busy stays 0.
- MULT -3 (0xFFFF_FFFD) x 7 -> busy high for 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. MULTU of the same operands -> hi=0x0000_0006, lo=0xFFFF_FFEB.
- DIV -7 / 2 -> after 33 cycles lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 5 / 0 -> lo=0xFFFF_FFFF, hi=5. DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
- Start DIV, pulse flush at cycle 10 -> next cycle busy=0 and hi/lo keep prior values. A new MULT started right after completes normally.
- Start MULT, then assert start with DIVU at cycle 2 -> DIVU is ignored and the MULT result lands on schedule. Async reset at cycle 3 of a DIV -> hi=lo=0 and busy=0 immediately.
